iter_mul_unit: RTL and testbench



---
 rtl/iter_mul_unit_if.sv | 33 +++
 rtl/iter_mul_unit.sv | 135 +++++++++++++
 tb/tb_iter_mul_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/iter_mul_unit_if.sv
// Purpose: request/result bundle between the register-file datapath and iter_mul_unit.
// Latency: n/a (wires only).
// Backpressure: none; requester watches busy, and start is ignored while busy is high.
// Signals: start/op_signed/src_a/src_b/dst travel requester -> unit;
//          busy/wr_en/wr_reg/wr_data/prod_hi/ovf travel unit -> register file and flag logic.
interface iter_mul_unit_if #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
);
    logic              start;
    logic              op_signed;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [REG_W-1:0]  dst;
    logic              busy;
    logic              wr_en;
    logic [REG_W-1:0]  wr_reg;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] prod_hi;
    logic              ovf;

    // Requester side: issues operations and observes the write-back.
    modport master (
        output start, op_signed, src_a, src_b, dst,
        input  busy, wr_en, wr_reg, wr_data, prod_hi, ovf
    );

    // Multiplier side.
    modport slave (
        input  start, op_signed, src_a, src_b, dst,
        output busy, wr_en, wr_reg, wr_data, prod_hi, ovf
    );
endinterface

// File: rtl/iter_mul_unit.sv
// Purpose: iterative 16x16 shift-add multiplier, signed or unsigned, with register-file write-back.
// Latency: accept at edge E -> wr_en high for the one cycle after edge E+17; 18 busy cycles.
// Backpressure: none downstream; start is sampled only in IDLE, so a start while busy is dropped.
// Ports: clk, rst (sync, active-high); bus (slave modport): start/op_signed/src_a/src_b/dst in,
//        busy/wr_en/wr_reg/wr_data (low product) and prod_hi/ovf (held until the next write-back) out.
module iter_mul_unit #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic          clk,
    input  logic          rst,
    iter_mul_unit_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        WB
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    count_q;
    logic [DATA_W-1:0]   mcand_q;     // |A|, added into the upper accumulator half
    logic [2*DATA_W-1:0] acc_q;       // {partial high, remaining multiplier bits / product low}
    logic                sgn_q;
    logic                neg_q;       // result must be negated in FIX
    logic [REG_W-1:0]    dst_q;

    logic                busy_q;
    logic                wr_en_q;
    logic [REG_W-1:0]    wr_reg_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic [DATA_W-1:0]   prod_hi_q;
    logic                ovf_q;

    logic [DATA_W-1:0]   mag_a_d;
    logic [DATA_W-1:0]   mag_b_d;
    logic                neg_d;
    logic [DATA_W:0]     sum_d;
    logic [2*DATA_W-1:0] acc_d;
    logic [2*DATA_W-1:0] prod_d;
    logic                ovf_d;

    // Operand magnitudes. 0x8000 negates to itself, which is the correct
    // unsigned magnitude, so no special case is needed.
    always_comb begin
        mag_a_d = (bus.op_signed && bus.src_a[DATA_W-1]) ? -bus.src_a : bus.src_a;
        mag_b_d = (bus.op_signed && bus.src_b[DATA_W-1]) ? -bus.src_b : bus.src_b;
        neg_d   = bus.op_signed && (bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1]);
    end

    // One shift-add step: the extra sum bit is the carry that shifts into the MSB.
    always_comb begin
        sum_d = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_d = {sum_d, acc_q[DATA_W-1:1]};
    end

    // Final sign fix-up and overflow: signed result fits only if the high half
    // is pure sign extension of the low half.
    always_comb begin
        prod_d = neg_q ? -acc_q : acc_q;
        if (sgn_q) begin
            ovf_d = prod_d[2*DATA_W-1:DATA_W] != {DATA_W{prod_d[DATA_W-1]}};
        end else begin
            ovf_d = prod_d[2*DATA_W-1:DATA_W] != '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            sgn_q     <= 1'b0;
            neg_q     <= 1'b0;
            dst_q     <= '0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
            prod_hi_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mcand_q <= mag_a_d;
                        acc_q   <= {{DATA_W{1'b0}}, mag_b_d};
                        sgn_q   <= bus.op_signed;
                        neg_q   <= neg_d;
                        dst_q   <= bus.dst;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q   <= acc_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST_STEP) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    // Results are registered here so they are visible during WB.
                    wr_en_q   <= 1'b1;
                    wr_reg_q  <= dst_q;
                    wr_data_q <= prod_d[DATA_W-1:0];
                    prod_hi_q <= prod_d[2*DATA_W-1:DATA_W];
                    ovf_q     <= ovf_d;
                    state_q   <= WB;
                end
                WB: begin
                    wr_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_reg  = wr_reg_q;
    assign bus.wr_data = wr_data_q;
    assign bus.prod_hi = prod_hi_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_iter_mul_unit.sv
// Purpose: directed self-checking bench for iter_mul_unit.
// Latency: expects wr_en in the 18th cycle after the accept edge.
// Backpressure: drives start only when the unit should be idle, except where the drop is under test.
module tb_iter_mul_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    iter_mul_unit_if #(.DATA_W(16), .REG_W(4)) bus ();

    iter_mul_unit #(.DATA_W(16), .REG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request for one cycle; returns at the negedge just after the accept edge.
    task automatic launch(input logic sgn, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] d);
        @(negedge clk);
        bus.op_signed = sgn;
        bus.src_a     = a;
        bus.src_b     = b;
        bus.dst       = d;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    // Called at the first negedge after acceptance. Waits (bounded) for wr_en,
    // checks latency, busy span, payload and that the strobe lasts one cycle.
    task automatic wait_wb(input string tag, input logic churn, input logic [3:0] e_reg,
                           input logic [15:0] e_lo, input logic [15:0] e_hi, input logic e_ovf);
        int cyc;
        int nbusy;
        logic got;
        cyc   = 1;
        nbusy = 0;
        got   = 1'b0;
        while (cyc <= 40 && !got) begin
            if (bus.busy) nbusy++;
            if (bus.wr_en) begin
                got = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
                if (churn) begin
                    bus.src_a     = 16'($urandom);
                    bus.src_b     = 16'($urandom);
                    bus.dst       = 4'($urandom);
                    bus.op_signed = 1'($urandom);
                end
            end
        end
        chk({tag, "_lat"},   32'(cyc), 32'd18);
        chk({tag, "_busy"},  32'(nbusy), 32'd18);
        chk({tag, "_reg"},   32'(bus.wr_reg), 32'(e_reg));
        chk({tag, "_lo"},    32'(bus.wr_data), 32'(e_lo));
        chk({tag, "_hi"},    32'(bus.prod_hi), 32'(e_hi));
        chk({tag, "_ovf"},   32'(bus.ovf), 32'(e_ovf));
        @(negedge clk);
        chk({tag, "_wren0"}, 32'(bus.wr_en), 32'd0);
        chk({tag, "_idle"},  32'(bus.busy), 32'd0);
    endtask

    initial begin
        int nwr;
        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.op_signed = 1'b0;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.dst       = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_wren",  32'(bus.wr_en), 32'd0);
        chk("rst_reg",   32'(bus.wr_reg), 32'd0);
        chk("rst_data",  32'(bus.wr_data), 32'd0);
        chk("rst_hi",    32'(bus.prod_hi), 32'd0);
        chk("rst_ovf",   32'(bus.ovf), 32'd0);
        rst = 1'b0;

        // Basic unsigned, signed, and overflow vectors.
        launch(1'b0, 16'd3, 16'd5, 4'd4);
        wait_wb("u3x5", 1'b0, 4'd4, 16'h000F, 16'h0000, 1'b0);
        launch(1'b1, 16'hFFFD, 16'h0007, 4'd7);
        wait_wb("sm3x7", 1'b0, 4'd7, 16'hFFEB, 16'hFFFF, 1'b0);
        launch(1'b1, 16'h7FFF, 16'h0002, 4'd1);
        wait_wb("s7fffx2", 1'b0, 4'd1, 16'hFFFE, 16'h0000, 1'b1);
        launch(1'b1, 16'h8000, 16'h8000, 4'd2);
        wait_wb("s8000sq", 1'b0, 4'd2, 16'h0000, 16'h4000, 1'b1);
        launch(1'b0, 16'hFFFF, 16'hFFFF, 4'd15);
        wait_wb("uffffsq", 1'b0, 4'd15, 16'h0001, 16'hFFFE, 1'b1);
        launch(1'b1, 16'h0000, 16'hFFFF, 4'd3);
        wait_wb("s0xm1", 1'b0, 4'd3, 16'h0000, 16'h0000, 1'b0);

        // Start held through the whole operation with new operands: the busy
        // start is dropped, then picked up in the IDLE cycle after WB.
        @(negedge clk);
        bus.op_signed = 1'b0;
        bus.src_a     = 16'd2;
        bus.src_b     = 16'd3;
        bus.dst       = 4'd5;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.src_a     = 16'd9;
        bus.src_b     = 16'd9;
        bus.dst       = 4'd6;
        wait_wb("b2b_first", 1'b0, 4'd5, 16'h0006, 16'h0000, 1'b0);
        // wait_wb ended in the IDLE cycle; start is still high, so the accept
        // happens at the next edge.
        @(negedge clk);
        bus.start = 1'b0;
        wait_wb("b2b_second", 1'b0, 4'd6, 16'h0051, 16'h0000, 1'b0);

        // Reset during CALC aborts the operation with no write-back.
        launch(1'b0, 16'd100, 16'd100, 4'd9);
        repeat (7) @(negedge clk);
        chk("abort_busy8", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy",  32'(bus.busy), 32'd0);
        chk("abort_wren",  32'(bus.wr_en), 32'd0);
        chk("abort_reg",   32'(bus.wr_reg), 32'd0);
        chk("abort_data",  32'(bus.wr_data), 32'd0);
        chk("abort_hi",    32'(bus.prod_hi), 32'd0);
        chk("abort_ovf",   32'(bus.ovf), 32'd0);
        nwr = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.wr_en) nwr++;
        end
        chk("abort_nowr", 32'(nwr), 32'd0);
        launch(1'b0, 16'd4, 16'd4, 4'd8);
        wait_wb("post_abort", 1'b0, 4'd8, 16'h0010, 16'h0000, 1'b0);

        // Operand churn after accept must not disturb the result.
        launch(1'b0, 16'h0012, 16'h0034, 4'd10);
        wait_wb("churn", 1'b1, 4'd10, 16'h03A8, 16'h0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
